// File: rtl/spi_pkg.sv
// Shared types and helpers for the SPI clock sequencer: FSM states, default widths
// and the CPHA/edge decode that picks which SCK edges sample and which shift.
package spi_pkg;

  localparam int unsigned DefDivW = 8;
  localparam int unsigned DefLenW = 5;

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StGuard
  } state_e;

  typedef struct packed {
    logic sample;
    logic shift;
  } strobe_t;

  // With CPHA=0 the first bit is already on the line at accept, so the final trailing edge
  // has nothing left to shift.
  function automatic strobe_t edge_strobe(input logic cpha, input logic leading,
                                          input logic last);
    strobe_t s;
    s.sample = 1'b0;
    s.shift  = 1'b0;
    if (cpha) begin
      s.shift  = leading;
      s.sample = ~leading;
    end else begin
      s.sample = leading;
      s.shift  = ~leading & ~last;
    end
    return s;
  endfunction

endpackage

// File: rtl/spi_tick_cnt.sv
// Loadable down-counter that pulses tick_o while enabled at zero and then reloads itself.
module spi_tick_cnt #(
  parameter int unsigned W = 8
) (
  input  logic         CLK,
  input  logic         RST,
  input  logic         load_i,
  input  logic         en_i,
  input  logic [W-1:0] val_i,
  output logic         tick_o
);

  logic [W-1:0] cnt_q;

  assign tick_o = en_i && (cnt_q == '0);

  always_ff @(posedge CLK) begin
    if (RST) begin
      cnt_q <= '0;
    end else if (load_i || tick_o) begin
      cnt_q <= val_i;
    end else if (en_i) begin
      cnt_q <= cnt_q - 1'b1;
    end
  end

endmodule

// File: rtl/spi_sck_ctrl.sv
// SPI serial-clock sequencer: runs one transfer per accepted START, emitting SCK plus
// SAMPLE/SHIFT strobes aligned to SCK edges and a DONE pulse at the end.
module spi_sck_ctrl
  import spi_pkg::*;
#(
  parameter int unsigned DIV_W = DefDivW,
  parameter int unsigned LEN_W = DefLenW
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             START,
  input  logic [DIV_W-1:0] DIV,
  input  logic [LEN_W-1:0] NBITS,
  input  logic             CPOL,
  input  logic             CPHA,
  output logic             BUSY,
  output logic             SCK,
  output logic             SAMPLE,
  output logic             SHIFT,
  output logic             DONE
);

  localparam logic [LEN_W:0] EdgeOne = 1;

  state_e           state_q;
  logic [DIV_W-1:0] div_q;
  logic [LEN_W-1:0] nbits_q;
  logic             cpol_q;
  logic             cpha_q;
  // Counts completed edges (0 .. 2N-1); one bit wider than NBITS so 2^LEN_W bits fit.
  logic [LEN_W:0]   edge_q;

  logic             accept;
  logic             tick;
  logic             last_edge;
  strobe_t          strb;

  assign accept    = (state_q == StIdle) && START;
  assign last_edge = (edge_q == {nbits_q, 1'b1});
  assign strb      = edge_strobe(cpha_q, ~edge_q[0], last_edge);

  spi_tick_cnt #(
    .W (DIV_W)
  ) u_tick_cnt (
    .CLK    (CLK),
    .RST    (RST),
    .load_i (accept),
    .en_i   (state_q != StIdle),
    .val_i  (accept ? DIV : div_q),
    .tick_o (tick)
  );

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= StIdle;
      BUSY    <= 1'b0;
      SCK     <= 1'b0;
      SAMPLE  <= 1'b0;
      SHIFT   <= 1'b0;
      DONE    <= 1'b0;
      edge_q  <= '0;
      div_q   <= '0;
      nbits_q <= '0;
      cpol_q  <= 1'b0;
      cpha_q  <= 1'b0;
    end else begin
      SAMPLE <= 1'b0;
      SHIFT  <= 1'b0;
      DONE   <= 1'b0;
      unique case (state_q)
        StIdle: begin
          SCK <= CPOL;
          if (START) begin
            div_q   <= DIV;
            nbits_q <= NBITS;
            cpol_q  <= CPOL;
            cpha_q  <= CPHA;
            edge_q  <= '0;
            BUSY    <= 1'b1;
            state_q <= StRun;
          end
        end
        StRun: begin
          if (tick) begin
            SCK    <= ~SCK;
            SAMPLE <= strb.sample;
            SHIFT  <= strb.shift;
            if (last_edge) begin
              edge_q  <= '0;
              state_q <= StGuard;
            end else begin
              edge_q <= edge_q + EdgeOne;
            end
          end
        end
        StGuard: begin
          if (tick) begin
            BUSY    <= 1'b0;
            DONE    <= 1'b1;
            state_q <= StIdle;
          end
        end
        default: begin
          BUSY    <= 1'b0;
          state_q <= StIdle;
        end
      endcase
    end
  end

endmodule

// File: doc/spi_sck_ctrl.md
Name: spi_sck_ctrl

Overview:
Sequences the SPI serial clock for one transfer at a time: programmable SCK half-period, mode 0-3 (CPOL/CPHA), and a programmable bit count. Accepts a START request from the Wishbone-side register block and emits SCK. It also emits one-cycle SAMPLE/SHIFT strobes for the shift register and a DONE pulse, so the shift register stays free of timing logic. Sits between the Wishbone slave registers and the SPI shift register, all in the CLK domain.

Parameters:
DIV_W, 8, width of DIV; SCK half-period = DIV+1 CLK cycles (1..2^DIV_W).
LEN_W, 5, width of NBITS; transfer length = NBITS+1 bits (1..2^LEN_W).

Ports:
CLK  in  1  system clock; all logic on posedge.
RST  in  1  synchronous, active-high reset.
START  in  1  transfer request; accepted only on a posedge where BUSY=0.
DIV  in  DIV_W  half-period minus one; latched on accept.
NBITS  in  LEN_W  bit count minus one; latched on accept.
CPOL  in  1  idle SCK level; latched on accept; tracked while idle.
CPHA  in  1  0 = sample on leading edge, 1 = shift on leading edge; latched on accept.
BUSY  out  1  high from the cycle after accept until the DONE cycle (exclusive).
SCK  out  1  registered SPI clock.
SAMPLE  out  1  one-cycle strobe coincident with an SCK sampling edge.
SHIFT  out  1  one-cycle strobe coincident with an SCK shifting edge.
DONE  out  1  one-cycle pulse at transfer end.

Behaviour:
- Reset (RST=1 at a posedge): state IDLE, BUSY=0, SCK=0, SAMPLE=0, SHIFT=0, DONE=0, counters 0. Reset mid-transfer aborts immediately with no DONE pulse.
- States: IDLE, RUN, GUARD.
- IDLE: SCK <= CPOL every cycle (1-cycle lag). START=1 latches DIV, NBITS, CPOL, CPHA. Next cycle: RUN, BUSY=1, SCK=CPOL latched, half-period counter = DIV, edge counter = 0.
- RUN: half-period counter decrements each cycle. At 0 it reloads DIV, SCK toggles and edge counter increments, all in the same registered update.
- Edge k (1-based, 1..2N, N = NBITS+1): odd k is a leading edge, even k is a trailing edge.
- CPHA=0: SAMPLE on every leading edge; SHIFT on trailing edges except k=2N. The first bit is presented by the shift register at accept.
- CPHA=1: SHIFT on every leading edge; SAMPLE on every trailing edge.
- SAMPLE and SHIFT are registered and high exactly in the cycle the new SCK value is first visible. They are never both high.
- After edge 2N: GUARD, SCK stays at CPOL, counter reloaded with DIV.
- GUARD: at counter 0, go to IDLE with DONE=1 and BUSY=0 in that same cycle.
- Timing, START accepted at posedge ending cycle 0:
  - BUSY=1 in cycles 1 .. (2N+1)(DIV+1).
  - Edge k visible at cycle 1 + k(DIV+1).
  - DONE visible at cycle 1 + (2N+1)(DIV+1).
- START while BUSY=1: ignored, no queuing. START in the DONE cycle (BUSY=0): accepted, giving back-to-back transfers. SCK stays at CPOL through that cycle.
- DIV/NBITS/CPOL/CPHA changes while BUSY=1 have no effect.
- DIV=0: SCK toggles every CLK cycle. DIV=all-ones: half-period 2^DIV_W cycles, with no counter overflow.
- NBITS=all-ones: 2^LEN_W bits; the edge counter is LEN_W+1 bits wide and must not wrap.

Decomposition:
- Package spi_pkg holds: state encoding (IDLE/RUN/GUARD), default DIV_W/LEN_W constants, and a mode-decode helper (CPHA, edge parity) -> {sample, shift}.
- One sub-module, spi_tick_cnt: loadable DIV_W down-counter. It outputs a one-cycle tick at zero and reloads automatically. It is instantiated once and shared by RUN and GUARD.

Test Plan:
- Mode 0, 8 bits (DIV=0, NBITS=7, CPOL=0, CPHA=0), START at cycle 0 -> BUSY cycles 1-17; SCK 0,1,0,1... with a rising edge at cycle 2; 8 SAMPLE on rises; 7 SHIFT; DONE at cycle 18.
- Mode 3, 4 bits, slow clock (DIV=3, NBITS=3, CPOL=1, CPHA=1) -> SCK idles high; first falling edge at cycle 5 with SHIFT; 4 SAMPLE on rising edges; DONE at cycle 37; SCK=1 throughout GUARD.
- START pulsed at cycles 0 and 5 plus config changes mid-transfer (DIV=0, NBITS=1) -> second START ignored; a single DONE at cycle 6; latched config used throughout.
- Back-to-back: START held high continuously, DIV=0, NBITS=0 -> DONE at cycle 4, second transfer accepted in the same cycle, second DONE at cycle 8; SCK never glitches between transfers.
- RST asserted at cycle 10 of an 8-bit DIV=1 transfer -> next cycle BUSY=0, SCK=0, no DONE; a new START after RST deasserts runs a full correct transfer.
- Boundaries: DIV=255, NBITS=31 -> half-period 256 cycles; exactly 64 edges; DONE at cycle 1+65*256=16641.
